// File: rtl/div_unit_if.sv
// div_unit_if: divider request/result bundle between execute control and the divider.
interface div_unit_if #(parameter int WIDTH = 32);
    logic Start;
    logic SignedOp;
    logic [WIDTH-1:0] Dividend;
    logic [WIDTH-1:0] Divisor;
    logic RDivAck;
    logic Busy;
    logic Done;
    logic RDiv;
    logic [WIDTH-1:0] Quotient;
    logic [WIDTH-1:0] R30;
    logic DivByZero;
    modport master (
        output Start, SignedOp, Dividend, Divisor, RDivAck,
        input Busy, Done, RDiv, Quotient, R30, DivByZero
    );
    modport slave (
        input Start, SignedOp, Dividend, Divisor, RDivAck,
        output Busy, Done, RDiv, Quotient, R30, DivByZero
    );
endinterface

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring signed/unsigned divider; remainder strobed to R30 via RDiv.
module div_unit #(
    parameter int WIDTH = 32
) (
    input logic nativeCLK,
    input logic Reset,
    div_unit_if.slave bus
);
    localparam int COUNT_W = $clog2(WIDTH) + 1;
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] PREP = 3'd1;
    localparam logic [2:0] ITER = 3'd2;
    localparam logic [2:0] FIX = 3'd3;
    localparam logic [2:0] DONE = 3'd4;
    logic [2:0] state;
    logic signedOp, qNeg, rNeg;
    logic [WIDTH-1:0] quo, dvs, rem;
    logic [COUNT_W-1:0] count;
    logic [WIDTH:0] shifted, diff;
    // quo starts as the dividend and shifts out its MSB while quotient bits shift in
    assign shifted = {rem, quo[WIDTH-1]};
    assign diff = shifted - {1'b0, dvs};
    assign bus.Busy = (state == PREP) || (state == ITER) || (state == FIX);
    always_ff @(posedge nativeCLK) begin
        if (Reset) begin
            state <= IDLE;
            signedOp <= 1'b0;
            qNeg <= 1'b0;
            rNeg <= 1'b0;
            quo <= '0;
            dvs <= '0;
            rem <= '0;
            count <= '0;
            bus.Done <= 1'b0;
            bus.RDiv <= 1'b0;
            bus.Quotient <= '0;
            bus.R30 <= '0;
            bus.DivByZero <= 1'b0;
        end else begin
            // RDiv rises one cycle after DONE entry so an ack can only follow a visible strobe
            bus.Done <= (state == DONE) && !bus.RDiv;
            bus.RDiv <= (state == DONE) && !(bus.RDiv && bus.RDivAck);
            case (state)
                IDLE: if (bus.Start) begin
                    state <= PREP;
                    signedOp <= bus.SignedOp;
                    quo <= bus.Dividend;
                    dvs <= bus.Divisor;
                end
                PREP: if (dvs == '0) begin
                    bus.Quotient <= '1;
                    bus.R30 <= quo;
                    bus.DivByZero <= 1'b1;
                    state <= DONE;
                end else begin
                    quo <= (signedOp && quo[WIDTH-1]) ? -quo : quo;
                    dvs <= (signedOp && dvs[WIDTH-1]) ? -dvs : dvs;
                    qNeg <= signedOp && (quo[WIDTH-1] ^ dvs[WIDTH-1]);
                    rNeg <= signedOp && quo[WIDTH-1];
                    rem <= '0;
                    count <= '0;
                    state <= ITER;
                end
                ITER: begin
                    rem <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], !diff[WIDTH]};
                    count <= count + 1'b1;
                    state <= (count == COUNT_W'(WIDTH - 1)) ? FIX : ITER;
                end
                FIX: begin
                    bus.Quotient <= qNeg ? -quo : quo;
                    bus.R30 <= rNeg ? -rem : rem;
                    bus.DivByZero <= 1'b0;
                    state <= DONE;
                end
                DONE: if (bus.RDiv && bus.RDivAck) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: randomized divisions checked against an arithmetic reference model.
module tb_div_unit;
    localparam int W = 32;
    logic nativeCLK = 1'b0;
    logic Reset = 1'b1;
    div_unit_if #(.WIDTH(W)) bus();
    div_unit #(.WIDTH(W)) dut (.nativeCLK(nativeCLK), .Reset(Reset), .bus(bus));
    always #5 nativeCLK = ~nativeCLK;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int startCyc = 0;
    int expLat = 0;
    logic active = 1'b0;
    logic prevRDiv = 1'b0;
    logic [W-1:0] expQ, expR;
    logic expZ;
    always @(posedge nativeCLK) cyc <= cyc + 1;
    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at cycle %0d", name, act, exp, cyc);
        end
    endtask
    task automatic model(input logic sop, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
        z = (b == '0);
        if (z) begin
            q = '1;
            r = a;
        end else if (!sop) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == '1) begin
            q = a;
            r = '0;
        end else begin
            q = W'($signed(a) / $signed(b));
            r = W'($signed(a) % $signed(b));
        end
    endtask
    always @(negedge nativeCLK) begin
        if (active && bus.RDiv) begin
            chk("done_pulse", W'(bus.Done), W'(!prevRDiv));
            if (!prevRDiv) chk("latency", cyc - startCyc, expLat);
            chk("quotient", bus.Quotient, expQ);
            chk("r30", bus.R30, expR);
            chk("divbyzero", W'(bus.DivByZero), W'(expZ));
        end else if (active) begin
            chk("done_low", W'(bus.Done), 0);
        end
        prevRDiv <= bus.RDiv;
    end
    task automatic doDiv(input logic sop, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int ackDelay, input bit midStart);
        logic [W-1:0] q, r;
        logic z;
        int n;
        model(sop, a, b, q, r, z);
        @(negedge nativeCLK);
        bus.Start = 1'b1;
        bus.SignedOp = sop;
        bus.Dividend = a;
        bus.Divisor = b;
        @(posedge nativeCLK);
        #1;
        startCyc = cyc;
        expQ = q;
        expR = r;
        expZ = z;
        expLat = (b == '0) ? 2 : W + 3;
        active = 1'b1;
        bus.Start = 1'b0;
        bus.SignedOp = ~sop;
        bus.Dividend = $urandom;
        bus.Divisor = $urandom;
        n = 0;
        while (!bus.RDiv && n < 60) begin
            @(negedge nativeCLK);
            n++;
            bus.Start = midStart && n == 10;
        end
        bus.Start = 1'b0;
        chk("rdiv_timeout", W'(bus.RDiv), 1);
        repeat (ackDelay) begin
            @(negedge nativeCLK);
            chk("rdiv_hold", W'(bus.RDiv), 1);
        end
        @(negedge nativeCLK);
        bus.RDivAck = 1'b1;
        @(posedge nativeCLK);
        #1;
        bus.RDivAck = 1'b0;
        active = 1'b0;
        chk("rdiv_drop", W'(bus.RDiv), 0);
        chk("q_held", bus.Quotient, q);
        chk("busy_idle", W'(bus.Busy), 0);
    endtask
    initial begin
        logic [W-1:0] q, r, a, b;
        logic z, sop;
        bus.Start = 1'b0;
        bus.SignedOp = 1'b0;
        bus.Dividend = '0;
        bus.Divisor = '0;
        bus.RDivAck = 1'b0;
        model(1'b0, 100, 7, q, r, z);
        chk("model_100_7_q", q, 14);
        chk("model_100_7_r", r, 2);
        model(1'b1, 32'hFFFF_FFF9, 2, q, r, z);
        chk("model_m7_2_q", q, 32'hFFFF_FFFD);
        chk("model_m7_2_r", r, 32'hFFFF_FFFF);
        model(1'b1, 7, 32'hFFFF_FFFE, q, r, z);
        chk("model_7_m2_r", r, 1);
        repeat (3) @(posedge nativeCLK);
        #1;
        chk("rst_busy", W'(bus.Busy), 0);
        chk("rst_rdiv", W'(bus.RDiv), 0);
        chk("rst_done", W'(bus.Done), 0);
        chk("rst_q", bus.Quotient, 0);
        chk("rst_r30", bus.R30, 0);
        @(negedge nativeCLK);
        Reset = 1'b0;
        doDiv(1'b0, 100, 7, 0, 1'b0);
        chk("t1_q", bus.Quotient, 14);
        chk("t1_r", bus.R30, 2);
        doDiv(1'b1, 32'hFFFF_FFF9, 2, 1, 1'b0);
        chk("t2a_q", bus.Quotient, 32'hFFFF_FFFD);
        chk("t2a_r", bus.R30, 32'hFFFF_FFFF);
        doDiv(1'b1, 7, 32'hFFFF_FFFE, 0, 1'b0);
        chk("t2b_q", bus.Quotient, 32'hFFFF_FFFD);
        chk("t2b_r", bus.R30, 1);
        doDiv(1'b0, 5, 0, 2, 1'b0);
        chk("t3_q", bus.Quotient, 32'hFFFF_FFFF);
        chk("t3_r", bus.R30, 5);
        chk("t3_z", W'(bus.DivByZero), 1);
        doDiv(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        chk("t4a_q", bus.Quotient, 32'h8000_0000);
        chk("t4a_r", bus.R30, 0);
        doDiv(1'b0, 1000, 7, 20, 1'b1);
        chk("t5_q", bus.Quotient, 142);
        doDiv(1'b0, 32'hFFFF_FFFF, 1, 0, 1'b0);
        chk("t4b_q", bus.Quotient, 32'hFFFF_FFFF);
        chk("t4b_r", bus.R30, 0);
        @(negedge nativeCLK);
        bus.Start = 1'b1;
        bus.SignedOp = 1'b0;
        bus.Dividend = 1000;
        bus.Divisor = 7;
        @(negedge nativeCLK);
        bus.Start = 1'b0;
        repeat (11) @(negedge nativeCLK);
        chk("pre_rst_busy", W'(bus.Busy), 1);
        Reset = 1'b1;
        @(posedge nativeCLK);
        #1;
        chk("mid_rst_busy", W'(bus.Busy), 0);
        chk("mid_rst_rdiv", W'(bus.RDiv), 0);
        chk("mid_rst_q", bus.Quotient, 0);
        chk("mid_rst_r30", bus.R30, 0);
        @(negedge nativeCLK);
        Reset = 1'b0;
        doDiv(1'b0, 9, 3, 0, 1'b0);
        chk("t6_q", bus.Quotient, 3);
        chk("t6_r", bus.R30, 0);
        for (int i = 0; i < 40; i++) begin
            sop = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 3))
                0: b = '0;
                1: b = W'($urandom_range(1, 20));
                2: b = $urandom;
                default: b = -W'($urandom_range(1, 20));
            endcase
            doDiv(sop, a, b, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
